// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: icache, redirect and decode-side signals of the fetch queue.
// Defining FETCHQ_PERF_EN adds the full-stall and miss-wait counters.
interface if_fetch_queue_if #(parameter int QUEUE_DEPTH = 8);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic [63:0] Icache_data_out;
  logic Icache_valid_out;
  logic [63:0] proc2Icache_addr;
  logic redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0] deq_count;
  logic [31:0] inst0, inst1;
  logic [63:0] pc0, pc1;
  logic valid0, valid1;
  logic [CW-1:0] free_count;
`ifdef FETCHQ_PERF_EN
  logic [31:0] fq_full_stall_cycles, fq_miss_wait_cycles;
  modport slave (
    input Icache_data_out, Icache_valid_out, redirect_valid, redirect_pc, deq_count,
    output proc2Icache_addr, inst0, inst1, pc0, pc1, valid0, valid1, free_count,
    output fq_full_stall_cycles, fq_miss_wait_cycles
  );
  modport master (
    output Icache_data_out, Icache_valid_out, redirect_valid, redirect_pc, deq_count,
    input proc2Icache_addr, inst0, inst1, pc0, pc1, valid0, valid1, free_count,
    input fq_full_stall_cycles, fq_miss_wait_cycles
  );
`else
  modport slave (
    input Icache_data_out, Icache_valid_out, redirect_valid, redirect_pc, deq_count,
    output proc2Icache_addr, inst0, inst1, pc0, pc1, valid0, valid1, free_count
  );
  modport master (
    output Icache_data_out, Icache_valid_out, redirect_valid, redirect_pc, deq_count,
    input proc2Icache_addr, inst0, inst1, pc0, pc1, valid0, valid1, free_count
  );
`endif
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC + icache line splitter feeding a circular instruction queue for decode.
// Defining FETCHQ_PERF_EN adds saturating full-stall and miss-wait cycle counters.
module if_fetch_queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic clock,
  input logic reset,
  if_fetch_queue_if.slave fq
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {FETCH, FULL_WAIT} state_t;
  state_t state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CW-1:0] count_q, count_d, free_q, deq_req, deq_n, enq_n, need_n;
  logic [31:0] inst_q [QUEUE_DEPTH];
  logic [63:0] epc_q [QUEUE_DEPTH];
  // An upper-half PC only yields the high word of the line
  assign need_n = pc_q[2] ? CW'(1) : CW'(2);
  assign deq_req = fq.deq_count[1] ? CW'(2) : CW'(fq.deq_count[0]);
  assign deq_n = deq_req > count_q ? count_q : deq_req;
  assign head1 = head_q + PW'(1);
  assign tail1 = tail_q + PW'(1);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    enq_n = '0;
    if (fq.redirect_valid) begin
      state_d = FETCH;
      pc_d = fq.redirect_pc & ~64'h3;
    end else if (state_q == FETCH) begin
      if (fq.Icache_valid_out && free_q >= need_n) begin
        enq_n = need_n;
        pc_d = pc_q + (pc_q[2] ? 64'd4 : 64'd8);
      end else if (fq.Icache_valid_out) state_d = FULL_WAIT;
    end else if (free_q + deq_n >= need_n) state_d = FETCH;
  end
  assign count_d = fq.redirect_valid ? '0 : count_q + enq_n - deq_n;
  assign head_d = fq.redirect_valid ? '0 : head_q + PW'(deq_n);
  assign tail_d = fq.redirect_valid ? '0 : tail_q + PW'(enq_n);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      free_q <= CW'(QUEUE_DEPTH);
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        inst_q[i] <= '0;
        epc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      free_q <= CW'(QUEUE_DEPTH) - count_d;
      if (enq_n != '0) begin
        inst_q[tail_q] <= pc_q[2] ? fq.Icache_data_out[63:32] : fq.Icache_data_out[31:0];
        epc_q[tail_q] <= pc_q;
        if (!pc_q[2]) begin
          inst_q[tail1] <= fq.Icache_data_out[63:32];
          epc_q[tail1] <= pc_q + 64'd4;
        end
      end
    end
  end
  assign fq.proc2Icache_addr = {pc_q[63:3], 3'b000};
  assign fq.inst0 = inst_q[head_q];
  assign fq.pc0 = epc_q[head_q];
  assign fq.inst1 = inst_q[head1];
  assign fq.pc1 = epc_q[head1];
  assign fq.valid0 = count_q != '0;
  assign fq.valid1 = count_q >= CW'(2);
  assign fq.free_count = free_q;
`ifdef FETCHQ_PERF_EN
  logic [31:0] stall_q, miss_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      miss_q <= '0;
    end else begin
      if (state_q == FULL_WAIT && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (state_q == FETCH && !fq.Icache_valid_out && !fq.redirect_valid && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end
  assign fq.fq_full_stall_cycles = stall_q;
  assign fq.fq_miss_wait_cycles = miss_q;
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed fetch-queue scenarios; an in-order scoreboard checks every (inst, pc) decode consumes.
module tb_if_fetch_queue;
  logic clock = 0;
  logic reset = 0;
  logic use_fixed = 1;
  logic [63:0] fixed_line = 64'h0;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct packed {logic [31:0] inst; logic [63:0] pc;} ent_t;
  ent_t sb[$];

  if_fetch_queue_if #(.QUEUE_DEPTH(8)) fq ();
  if_fetch_queue #(.QUEUE_DEPTH(8), .RESET_PC(64'h0)) dut (.clock(clock), .reset(reset), .fq(fq));

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  assign fq.Icache_data_out = use_fixed ? fixed_line
                            : {word(fq.proc2Icache_addr | 64'h4), word(fq.proc2Icache_addr)};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [63:0] pc);
    sb.push_back({word(pc), pc});
  endtask

  task automatic pushf(input logic [31:0] i, input logic [63:0] pc);
    sb.push_back({i, pc});
  endtask

  task automatic pop(input string name, input logic [31:0] inst, input logic [63:0] pc);
    ent_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_underflow: got pc %h expected no entry", name, pc);
    end else begin
      e = sb.pop_front();
      chk({name, "_inst"}, 64'(inst), 64'(e.inst));
      chk({name, "_pc"}, pc, e.pc);
    end
  endtask

  // Monitor: every entry decode consumes must match the next expected one
  always @(negedge clock) begin
    if (reset && !fq.redirect_valid && fq.deq_count != 2'd0 && fq.valid0) begin
      pop("deq0", fq.inst0, fq.pc0);
      if (fq.deq_count[1] && fq.valid1) pop("deq1", fq.inst1, fq.pc1);
    end
  end

  initial begin
    fq.Icache_valid_out = 1;
    fixed_line = 64'hBBBBBBBB_AAAAAAAA;
    fq.redirect_valid = 0;
    fq.redirect_pc = 0;
    fq.deq_count = 0;
    #7;
    chk("rst_valid0", 64'(fq.valid0), 0);
    chk("rst_valid1", 64'(fq.valid1), 0);
    chk("rst_inst0", 64'(fq.inst0), 0);
    chk("rst_pc0", fq.pc0, 0);
    chk("rst_free", 64'(fq.free_count), 8);
    chk("rst_addr", fq.proc2Icache_addr, 0);
    @(negedge clock);
    reset = 1;
    cyc();
    chk("t1_valid0", 64'(fq.valid0), 1);
    chk("t1_valid1", 64'(fq.valid1), 1);
    chk("t1_inst0", 64'(fq.inst0), 64'hAAAAAAAA);
    chk("t1_pc0", fq.pc0, 0);
    chk("t1_inst1", 64'(fq.inst1), 64'hBBBBBBBB);
    chk("t1_pc1", fq.pc1, 4);
    chk("t1_addr", fq.proc2Icache_addr, 8);
    chk("t1_free", 64'(fq.free_count), 6);
    fq.Icache_valid_out = 0;
    pushf(32'hAAAAAAAA, 0);
    pushf(32'hBBBBBBBB, 4);
    fq.deq_count = 2;
    cyc();
    fq.deq_count = 0;
    chk("t1_drain_valid0", 64'(fq.valid0), 0);
    chk("t1_drain_free", 64'(fq.free_count), 8);
    chk("t1_hold_addr", fq.proc2Icache_addr, 8);
    // Redirect into the upper half of a line; valid data in the redirect cycle is dropped
    fixed_line = 64'h22222222_11111111;
    fq.Icache_valid_out = 1;
    fq.redirect_valid = 1;
    fq.redirect_pc = 64'h107;
    cyc();
    fq.redirect_valid = 0;
    chk("t2_redir_valid0", 64'(fq.valid0), 0);
    chk("t2_redir_addr", fq.proc2Icache_addr, 64'h100);
    cyc();
    fq.Icache_valid_out = 0;
    chk("t2_inst0", 64'(fq.inst0), 64'h22222222);
    chk("t2_pc0", fq.pc0, 64'h104);
    chk("t2_valid1", 64'(fq.valid1), 0);
    chk("t2_addr", fq.proc2Icache_addr, 64'h108);
    chk("t2_free", 64'(fq.free_count), 7);
    pushf(32'h22222222, 64'h104);
    fq.deq_count = 2;
    cyc();
    fq.deq_count = 0;
    chk("t2_deq_min_free", 64'(fq.free_count), 8);
    // Fill to full, stall, then free exactly one line's worth
    use_fixed = 0;
    fq.redirect_valid = 1;
    fq.redirect_pc = 64'h200;
    cyc();
    fq.redirect_valid = 0;
    fq.Icache_valid_out = 1;
    for (int i = 0; i < 8; i++) push(64'h200 + 64'(4 * i));
    cyc(4);
    chk("t3_full_free", 64'(fq.free_count), 0);
    chk("t3_full_addr", fq.proc2Icache_addr, 64'h220);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_wait_addr", fq.proc2Icache_addr, 64'h220);
      chk("t3_wait_free", 64'(fq.free_count), 0);
    end
    chk("t3_head_pc", fq.pc0, 64'h200);
    fq.deq_count = 2;
    cyc();
    fq.deq_count = 0;
    chk("t3_resume_free", 64'(fq.free_count), 2);
    chk("t3_resume_addr", fq.proc2Icache_addr, 64'h220);
    cyc();
    fq.Icache_valid_out = 0;
    push(64'h220);
    push(64'h224);
    chk("t3_refill_free", 64'(fq.free_count), 0);
    chk("t3_refill_addr", fq.proc2Icache_addr, 64'h228);
    fq.deq_count = 2;
    cyc(4);
    fq.deq_count = 0;
    chk("t3_drained_free", 64'(fq.free_count), 8);
    chk("t3_drained_valid0", 64'(fq.valid0), 0);
    // Miss: address and occupancy held while the icache is not valid
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_miss_addr", fq.proc2Icache_addr, 64'h228);
      chk("t4_miss_free", 64'(fq.free_count), 8);
    end
    fq.Icache_valid_out = 1;
    push(64'h228);
    push(64'h22C);
    cyc();
    fq.Icache_valid_out = 0;
    chk("t4_hit_free", 64'(fq.free_count), 6);
    chk("t4_hit_addr", fq.proc2Icache_addr, 64'h230);
    chk("t4_hit_pc1", fq.pc1, 64'h22C);
    // Redirect wins over a simultaneous enqueue and dequeue
    fq.Icache_valid_out = 1;
    fq.deq_count = 2;
    fq.redirect_valid = 1;
    fq.redirect_pc = 64'h3F0;
    sb.delete();
    cyc();
    fq.redirect_valid = 0;
    fq.deq_count = 0;
    chk("t5_valid0", 64'(fq.valid0), 0);
    chk("t5_free", 64'(fq.free_count), 8);
    chk("t5_addr", fq.proc2Icache_addr, 64'h3F0);
    // Async reset in the middle of a full stall
    cyc(5);
    chk("t6_full_free", 64'(fq.free_count), 0);
    chk("t6_full_addr", fq.proc2Icache_addr, 64'h410);
    #3;
    reset = 0;
    #1;
    chk("t6_rst_valid0", 64'(fq.valid0), 0);
    chk("t6_rst_valid1", 64'(fq.valid1), 0);
    chk("t6_rst_inst0", 64'(fq.inst0), 0);
    chk("t6_rst_pc0", fq.pc0, 0);
    chk("t6_rst_free", 64'(fq.free_count), 8);
    chk("t6_rst_addr", fq.proc2Icache_addr, 0);
    @(negedge clock);
    reset = 1;
    cyc();
    fq.Icache_valid_out = 0;
    chk("t6_restart_pc0", fq.pc0, 0);
    chk("t6_restart_inst0", 64'(fq.inst0), 64'h5A5A0000);
    chk("t6_restart_pc1", fq.pc1, 4);
    chk("t6_restart_addr", fq.proc2Icache_addr, 8);
    push(0);
    push(4);
    fq.deq_count = 3;
    cyc();
    fq.deq_count = 0;
    chk("t6_deq3_free", 64'(fq.free_count), 8);
    // PC wrap past the top of the address space
    fq.redirect_valid = 1;
    fq.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    cyc();
    fq.redirect_valid = 0;
    fq.Icache_valid_out = 1;
    cyc();
    fq.Icache_valid_out = 0;
    chk("t7_wrap_addr", fq.proc2Icache_addr, 0);
    chk("t7_wrap_pc1", fq.pc1, 64'hFFFF_FFFF_FFFF_FFFC);
    push(64'hFFFF_FFFF_FFFF_FFF8);
    push(64'hFFFF_FFFF_FFFF_FFFC);
    fq.deq_count = 2;
    cyc();
    fq.deq_count = 0;
    chk("t7_free", 64'(fq.free_count), 8);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
